// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, arbiter states and the
// clocks-per-bit divisor used by both the tx arbiter and the rx datapath.
package uart_pkg;

  localparam logic [3:0] BAUD_9600   = 4'd0;
  localparam logic [3:0] BAUD_110    = 4'd1;
  localparam logic [3:0] BAUD_300    = 4'd2;
  localparam logic [3:0] BAUD_600    = 4'd3;
  localparam logic [3:0] BAUD_1200   = 4'd4;
  localparam logic [3:0] BAUD_2400   = 4'd5;
  localparam logic [3:0] BAUD_4800   = 4'd6;
  localparam logic [3:0] BAUD_14400  = 4'd7;
  localparam logic [3:0] BAUD_19200  = 4'd8;
  localparam logic [3:0] BAUD_38400  = 4'd9;
  localparam logic [3:0] BAUD_57600  = 4'd10;
  localparam logic [3:0] BAUD_115200 = 4'd11;
  localparam logic [3:0] BAUD_128000 = 4'd12;
  localparam logic [3:0] BAUD_256000 = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    LOCKED
  } arb_state_t;

  // Each branch divides by a constant so that, with clk_freq a parameter,
  // the whole function folds to a small lookup table. Unused codes 14/15
  // fall back to 9600 baud.
  function automatic logic [15:0] hold_len_for(input logic [3:0] code,
                                               input int unsigned clk_freq);
    int unsigned q;
    case (code)
      BAUD_110:    q = clk_freq / 32'd110;
      BAUD_300:    q = clk_freq / 32'd300;
      BAUD_600:    q = clk_freq / 32'd600;
      BAUD_1200:   q = clk_freq / 32'd1200;
      BAUD_2400:   q = clk_freq / 32'd2400;
      BAUD_4800:   q = clk_freq / 32'd4800;
      BAUD_14400:  q = clk_freq / 32'd14400;
      BAUD_19200:  q = clk_freq / 32'd19200;
      BAUD_38400:  q = clk_freq / 32'd38400;
      BAUD_57600:  q = clk_freq / 32'd57600;
      BAUD_115200: q = clk_freq / 32'd115200;
      BAUD_128000: q = clk_freq / 32'd128000;
      BAUD_256000: q = clk_freq / 32'd256000;
      default:     q = clk_freq / 32'd9600;
    endcase
    if (q > 32'd65535) begin
      q = 32'd65535;
    end
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr upward (wrapping) and
// returns the first active request as a one-hot vector and as an index.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  int pos;

  // Walk the N candidate slots starting at ptr and keep only the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// streams. Grants are held across multi-byte packets and the baud hold
// length register lives here so it can only change while the line is idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int unsigned CLK_FREQ     = 1000000,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_sel_baud,
  input  logic               i_cfg_wr,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  output logic [15:0]        o_hold_len,
  output logic               o_busy,
  output logic               o_cfg_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [N_REQ-1:0] grant;
  logic [7:0]       tx_data;
  logic             lock;
  logic [SW-1:0]    stall_cnt;
  logic [15:0]      hold_len;
  logic             cfg_err;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             owner_valid;
  logic [7:0]       owner_data;
  logic             owner_last;
  logic             release_grant;
  logic [IW-1:0]    next_ptr;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (i_req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IW'(1);

  // Select the current owner's valid, byte and last flag via the one-hot grant.
  always_comb begin
    owner_valid = |(i_req_valid & grant);
    owner_data  = '0;
    owner_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        owner_data = i_req_data[8*k +: 8];
        owner_last = i_req_last[k];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; also flags the cycles in which the grant is given up.
  always_comb begin
    next_state    = state;
    release_grant = 1'b0;
    case (state)
      IDLE:      if (pick_found) next_state = ISSUE;
      ISSUE:     next_state = START;
      START:     next_state = WAIT_ACK;
      WAIT_ACK:  if (i_tx_busy) next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (lock) begin
            next_state = LOCKED;
          end else begin
            next_state    = IDLE;
            release_grant = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (owner_valid) begin
          next_state = ISSUE;
        end else if (stall_cnt == STALL_LAST) begin
          next_state    = IDLE;
          release_grant = 1'b1;
        end
      end
      default:   next_state = IDLE;
    endcase
  end

  // Moore outputs: ready only in ISSUE, start strobe only in START.
  always_comb begin
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    o_busy      = (state != IDLE);
    if (state == ISSUE) begin
      o_req_ready = grant;
    end
    if (state == START) begin
      o_tx_start = 1'b1;
    end
  end

  // Grant, pointer, captured byte, lock/stall tracking and baud config.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      tx_data   <= '0;
      lock      <= 1'b0;
      stall_cnt <= '0;
      hold_len  <= hold_len_for(BAUD_9600, CLK_FREQ);
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (i_cfg_wr) begin
        if (state == IDLE && grant == '0) begin
          hold_len <= hold_len_for(i_sel_baud, CLK_FREQ);
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_onehot;
            owner <= pick_idx;
          end
        end
        ISSUE: begin
          tx_data <= owner_data;
          lock    <= ~owner_last;
        end
        WAIT_DONE: begin
          if (!i_tx_busy && lock) begin
            stall_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!owner_valid) begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        default: ;
      endcase

      if (release_grant) begin
        grant <= '0;
        ptr   <= next_ptr;
      end
    end
  end

  assign o_grant    = grant;
  assign o_tx_data  = tx_data;
  assign o_hold_len = hold_len;
  assign o_cfg_err  = cfg_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: baud config, single/multi-byte
// packets, round-robin order, lock timeout, config rejection and reset.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         sel_baud = '0;
  logic               cfg_wr = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_last = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy = 1'b0;
  logic [15:0]        hold_len;
  logic               busy;
  logic               cfg_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ(N_REQ),
    .CLK_FREQ(1000000),
    .LOCK_TIMEOUT(255)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sel_baud  (sel_baud),
    .i_cfg_wr    (cfg_wr),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_hold_len  (hold_len),
    .o_busy      (busy),
    .o_cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  // Poll (bounded) for a ready; check it is requester k and, if given, the latency.
  task automatic waitReady(input int k, input int exp_wait, input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) seen = 1'b1;
    end
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << k));
    checkOutput({tag, "_grant"}, 32'(grant), 32'(1 << k));
    if (exp_wait > 0) checkOutput({tag, "_latency"}, 32'(n), 32'(exp_wait));
  endtask

  // Starting at the ISSUE negedge: see START, act as a transmitter for one
  // frame, optionally try a config write during WAIT_DONE, then drop busy.
  task automatic finishByte(input int k, input logic [7:0] d, input bit cfg_probe, input string tag);
    @(negedge clk);
    checkOutput({tag, "_start"}, 32'(tx_start), 32'd1);
    checkOutput({tag, "_data"}, 32'(tx_data), 32'(d));
    checkOutput({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    req_valid[k] = 1'b0;
    tx_busy      = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_start_pulse"}, 32'(tx_start), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_data_hold"}, 32'(tx_data), 32'(d));
    if (cfg_probe) begin
      sel_baud = 4'd1;
      cfg_wr   = 1'b1;
    end
    @(negedge clk);
    if (cfg_probe) begin
      cfg_wr = 1'b0;
      checkOutput({tag, "_cfg_err"}, 32'(cfg_err), 32'd1);
      checkOutput({tag, "_hold_kept"}, 32'(hold_len), 32'd8);
    end
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    tx_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int codes[5];
    int exps[5];
    bit bad;
    codes = '{1, 13, 15, 7, 11};
    exps  = '{9090, 3, 104, 69, 8};

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_start", 32'(tx_start), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("rst_hold", 32'(hold_len), 32'd104);
    rst = 1'b0;

    // Config 115200 in IDLE
    @(negedge clk);
    sel_baud = 4'hB;
    cfg_wr   = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    checkOutput("cfg_115200", 32'(hold_len), 32'd8);
    checkOutput("cfg_no_err", 32'(cfg_err), 32'd0);

    // Divisor table spot checks
    for (int i = 0; i < 5; i++) begin
      sel_baud = 4'(codes[i]);
      cfg_wr   = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      checkOutput($sformatf("baud_code_%0d", codes[i]), 32'(hold_len), 32'(exps[i]));
    end

    // Single byte from requester 2
    applyStimulus(2, 1'b1, 8'hA5, 1'b1);
    waitReady(2, 1, "t2");
    finishByte(2, 8'hA5, 1'b0, "t2");
    @(negedge clk);
    checkOutput("t2_release", 32'(grant), 32'd0);
    checkOutput("t2_idle", 32'(busy), 32'd0);

    // Requesters 0 and 3 together with ptr=3: 3 first, then 0
    applyStimulus(0, 1'b1, 8'h30, 1'b1);
    applyStimulus(3, 1'b1, 8'h33, 1'b1);
    waitReady(3, 1, "t3a");
    finishByte(3, 8'h33, 1'b0, "t3a");
    waitReady(0, 2, "t3b");
    finishByte(0, 8'h30, 1'b0, "t3b");
    @(negedge clk);
    checkOutput("t3_release", 32'(grant), 32'd0);

    // 3-byte locked packet from requester 1 while requester 0 waits
    applyStimulus(1, 1'b1, 8'h11, 1'b0);
    applyStimulus(0, 1'b1, 8'h22, 1'b1);
    waitReady(1, 1, "t4a");
    finishByte(1, 8'h11, 1'b0, "t4a");
    applyStimulus(1, 1'b1, 8'h12, 1'b0);
    waitReady(1, 2, "t4b");
    finishByte(1, 8'h12, 1'b0, "t4b");
    applyStimulus(1, 1'b1, 8'h13, 1'b1);
    waitReady(1, 2, "t4c");
    finishByte(1, 8'h13, 1'b0, "t4c");
    waitReady(0, 2, "t4d");
    finishByte(0, 8'h22, 1'b0, "t4d");
    @(negedge clk);
    checkOutput("t4_release", 32'(grant), 32'd0);

    // Lock timeout: requester 2 locks then goes silent, requester 3 waits
    applyStimulus(2, 1'b1, 8'h5A, 1'b0);
    applyStimulus(3, 1'b1, 8'h77, 1'b1);
    waitReady(2, 1, "t5a");
    finishByte(2, 8'h5A, 1'b0, "t5a");
    bad = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (req_ready != '0) bad = 1'b1;
    end
    checkOutput("t5_no_ready_while_locked", 32'(bad), 32'd0);
    checkOutput("t5_grant_held", 32'(grant), 32'd4);
    @(negedge clk);
    checkOutput("t5_timeout_release", 32'(grant), 32'd0);
    waitReady(3, 1, "t5b");

    // Config write during WAIT_DONE is rejected
    finishByte(3, 8'h77, 1'b1, "t6");
    @(negedge clk);
    checkOutput("t6_cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    checkOutput("t6_hold_unchanged", 32'(hold_len), 32'd8);
    checkOutput("t6_release", 32'(grant), 32'd0);

    // Config and valid in the same IDLE cycle: both take effect
    sel_baud = 4'd4;
    cfg_wr   = 1'b1;
    applyStimulus(1, 1'b1, 8'h99, 1'b1);
    @(negedge clk);
    cfg_wr = 1'b0;
    checkOutput("t7_hold_1200", 32'(hold_len), 32'd833);
    checkOutput("t7_ready", 32'(req_ready), 32'd2);
    checkOutput("t7_no_err", 32'(cfg_err), 32'd0);
    finishByte(1, 8'h99, 1'b0, "t7");
    @(negedge clk);
    checkOutput("t7_release", 32'(grant), 32'd0);

    // Reset during WAIT_ACK
    applyStimulus(0, 1'b1, 8'h3C, 1'b1);
    waitReady(0, 1, "t8");
    @(negedge clk);
    checkOutput("t8_start", 32'(tx_start), 32'd1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("t8_in_wait_ack", 32'(busy), 32'd1);
    checkOutput("t8_data", 32'(tx_data), 32'h3C);
    rst = 1'b1;
    #1;
    checkOutput("t8_rst_grant", 32'(grant), 32'd0);
    checkOutput("t8_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("t8_rst_start", 32'(tx_start), 32'd0);
    checkOutput("t8_rst_data", 32'(tx_data), 32'd0);
    checkOutput("t8_rst_busy", 32'(busy), 32'd0);
    checkOutput("t8_rst_cfg_err", 32'(cfg_err), 32'd0);
    checkOutput("t8_rst_hold", 32'(hold_len), 32'd104);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t8_after_rst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmit datapath among N_REQ byte-stream requesters. It grants one requester at a time and hands each byte to the transmitter with a one-cycle start strobe. It holds the grant across multi-byte packets and owns the baud configuration (hold length) driven to the UART datapaths. It sits between the peripheral-bus clients and the UART tx/rx cores.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CLK_FREQ, 1000000, i_clk frequency in Hz; used for the divisor
- LOCK_TIMEOUT, 255, idle cycles a locked requester may stall before its grant is revoked
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_sel_baud  in  4  baud select code; same encoding as the rx datapath
- i_cfg_wr  in  1  one-cycle strobe requesting that i_sel_baud be applied
- i_req_valid  in  N_REQ  per-requester byte valid
- i_req_data  in  8*N_REQ  byte for requester k on bits [8k+7:8k]
- i_req_last  in  N_REQ  byte is last of packet; 0 keeps the grant locked
- o_req_ready  out  N_REQ  one-hot ready; valid&ready is a byte transfer
- o_grant  out  N_REQ  one-hot current owner; 0 when no owner
- o_tx_start  out  1  one-cycle strobe to the transmitter
- o_tx_data  out  8  byte for the transmitter; stable from o_tx_start until i_tx_busy falls
- i_tx_busy  in  1  transmitter busy; high for the full frame
- o_hold_len  out  16  clocks per bit = CLK_FREQ / baud
- o_busy  out  1  high in every state except IDLE
- o_cfg_err  out  1  one-cycle pulse when a config write is rejected

## Operation
- Baud codes: 0→9600, 1→110, 2→300, 3→600, 4→1200, 5→2400, 6→4800, 7→14400, 8→19200, 9→38400, 10→57600, 11→115200, 12→128000, 13→256000, 14..15→9600.
- o_hold_len = integer floor of CLK_FREQ/baud, saturated to 16 bits. It is held in a register.
- Config write in IDLE with no grant: o_hold_len updates on the next edge.
- Config write in any other state: ignored, and o_cfg_err pulses the next cycle.
- Round-robin pointer ptr: search starts at ptr, then ptr+1, … modulo N_REQ. When a grant is released, ptr becomes winner+1 (mod N_REQ).
- The requester must hold valid and data stable until it sees ready. The arbiter does not re-check valid after the grant is given.
- States and transitions:
  - IDLE:
    - If any valid, pick the winner, set o_grant, and go to ISSUE.
  - ISSUE:
    - o_req_ready[winner]=1 for exactly this cycle.
    - Capture the byte into o_tx_data and capture last into a lock flag (lock = ~last).
    - Go to START.
  - START:
    - o_tx_start=1 for this cycle.
    - Go to WAIT_ACK.
  - WAIT_ACK:
    - Wait for i_tx_busy=1, then go to WAIT_DONE.
    - No timeout.
  - WAIT_DONE:
    - Wait for i_tx_busy=0.
    - If lock=0: release (o_grant←0, advance ptr) and go to IDLE.
    - If lock=1: go to LOCKED with the stall counter cleared.
  - LOCKED:
    - If valid[owner], go to ISSUE with the same owner.
    - Otherwise increment the stall counter. When it reaches LOCK_TIMEOUT, release and go to IDLE.
- Only the owner is ever readied; other requesters wait indefinitely.

## Timing
- Reset values:
  - state IDLE, ptr 0, lock 0, stall counter 0.
  - o_grant 0, o_req_ready 0, o_tx_start 0, o_tx_data 0x00.
  - o_busy 0, o_cfg_err 0.
  - o_hold_len = CLK_FREQ/9600 (104 at default).
- Latency from valid in IDLE to ready is 1 cycle. o_tx_start follows ready by 1 cycle.
- Minimum back-to-back gap within a locked packet: 2 cycles from busy falling to the next ready, through LOCKED then ISSUE.
- Several requesters rising in the same cycle: the lowest index at or after ptr wins.
- Reset asserted mid-frame: all outputs return to reset values immediately. The in-flight byte is abandoned, and the transmitter is not told.
- i_tx_busy already high at START: WAIT_ACK exits the next cycle.
- Config write in the same cycle that IDLE sees a valid: the config is applied and the grant is still issued, because both are decided in IDLE.

## Structure
- Package uart_pkg:
  - baud code constants.
  - state enum: IDLE, ISSUE, START, WAIT_ACK, WAIT_DONE, LOCKED.
  - a divisor function (code, clk_freq) → 16-bit hold length.
  - The rx datapath reuses the same function.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the request vector and ptr; outputs are a one-hot winner and its index.

## Test plan
- Reset, then sel_baud=0xB with cfg_wr in IDLE → o_hold_len=8 (1000000/115200) the next cycle; o_cfg_err stays 0.
- Requester 2 sends a single byte 0xA5 with last=1 → ready[2] one cycle later, then tx_start with tx_data=0xA5. After busy 0→1→0 the grant releases and ptr=3.
- Requesters 0 and 3 are valid together with ptr=3, each sending one byte with last=1 → requester 3 is served first, then 0, and ptr ends at 1.
- Requester 1 sends a 3-byte packet (last=0,0,1) while requester 0 is valid → requester 0 is not readied until requester 1's third byte completes.
- A locked requester drops valid for LOCK_TIMEOUT cycles → the grant is released and the waiting requester is granted within 2 cycles.
- cfg_wr during WAIT_DONE → o_hold_len is unchanged and o_cfg_err pulses for exactly 1 cycle.
- Reset asserted during WAIT_ACK → all outputs read their reset values before the next clock edge.
